// File: rtl/ram_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port data RAM between two requesters.
// Latency: grants are combinational; read data returns RD_LAT+1 cycles after the grant.
// Backpressure: a requester is stalled by holding gntN low and must keep its fields stable.
//
// Ports:
//   i_clk, i_rst                      clock and synchronous active-high reset
//   i_req0/i_we0/i_addr0/i_wdata0     port 0 (core load/store) request fields
//   o_gnt0, o_rvalid0, o_rdata0       port 0 grant and read return
//   i_req1/i_we1/i_addr1/i_wdata1     port 1 (loader/debug) request fields
//   i_lock1                           port 1 burst lock, sampled with i_req1
//   o_gnt1, o_rvalid1, o_rdata1       port 1 grant and read return
//   o_ram_addr/o_ram_wdata/o_ram_we   registered RAM command
//   i_ram_rdata                       RAM read data, valid RD_LAT cycles after the address
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_LOCK   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  input  logic                  i_lock1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] LOCK_ONE = CNT_W'(1);

  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;   // 0: port 0 granted last, 1: port 1
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;   // port-1 grants since the last port-0 slot

  logic             gnt0;
  logic             gnt1;

  // ---------------------------------------------------------------------------
  // RAM command registers and read-ownership tag pipeline
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;

  // Stage 0 lines up with the registered RAM address; stage RD_LAT lines up
  // with i_ram_rdata for that access.
  logic [RD_LAT:0]       tag_vld_q, tag_vld_d;
  logic [RD_LAT:0]       tag_own_q, tag_own_d;

  logic                  rd_issue;
  logic                  rd_owner;

  // ---------------------------------------------------------------------------
  // Next-state / grant logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;

    // Grants are forced low while reset is asserted.
    if (!i_rst) begin
      unique case (state_q)
        ST_RR: begin
          if (i_req0 && i_req1) begin
            // Contention: the port that did not win last time goes first.
            if (last_gnt_q) begin
              gnt0 = 1'b1;
            end else begin
              gnt1 = 1'b1;
            end
          end else begin
            gnt0 = i_req0;
            gnt1 = i_req1;
          end
          if (gnt1 && i_lock1) begin
            state_d    = ST_LOCKED;
            lock_cnt_d = LOCK_ONE;
          end
        end

        ST_LOCKED: begin
          if (i_req1 && i_lock1) begin
            if (i_req0 && (lock_cnt_q == LOCK_MAX)) begin
              // Starvation relief: one slot for port 0, burst continues after.
              gnt0       = 1'b1;
              lock_cnt_d = '0;
            end else begin
              gnt1 = 1'b1;
              // Saturate so an uncontended long burst never wraps the count.
              if (lock_cnt_q != LOCK_MAX) begin
                lock_cnt_d = lock_cnt_q + LOCK_ONE;
              end
            end
          end else begin
            // Lock released: leave in the same cycle, port 0 first.
            state_d    = ST_RR;
            lock_cnt_d = '0;
            gnt0       = i_req0;
            gnt1       = i_req1 && !i_req0;
          end
        end

        default: begin
          state_d    = ST_RR;
          lock_cnt_d = '0;
        end
      endcase

      if (gnt0) begin
        last_gnt_d = 1'b0;
      end else if (gnt1) begin
        last_gnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RR;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue path: winner's fields are captured on the accepting edge
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    rd_issue    = 1'b0;
    rd_owner    = 1'b0;

    if (gnt0) begin
      ram_addr_d  = i_addr0;
      ram_wdata_d = i_wdata0;
      ram_we_d    = i_we0;
      rd_issue    = !i_we0;
      rd_owner    = 1'b0;
    end else if (gnt1) begin
      ram_addr_d  = i_addr1;
      ram_wdata_d = i_wdata1;
      ram_we_d    = i_we1;
      rd_issue    = !i_we1;
      rd_owner    = 1'b1;
    end

    tag_vld_d = {tag_vld_q[RD_LAT-1:0], rd_issue};
    tag_own_d = {tag_own_q[RD_LAT-1:0], rd_owner};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_gnt0      = gnt0;
  assign o_gnt1      = gnt1;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_ram_we    = ram_we_q;

  // Returns landing in a reset cycle belong to dropped accesses.
  assign o_rvalid0   = tag_vld_q[RD_LAT] && !tag_own_q[RD_LAT] && !i_rst;
  assign o_rvalid1   = tag_vld_q[RD_LAT] &&  tag_own_q[RD_LAT] && !i_rst;

  // Read data is steered unconditionally; rvalid qualifies it.
  assign o_rdata0    = i_ram_rdata;
  assign o_rdata1    = i_ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share one stimulus
// stream; each has its own RAM behind it. Expected reads are queued at acceptance
// and matched against rvalid returns by a separate monitor.
module tb_ram_arbiter;

  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int MAXL = 8;
  localparam int LATA = 1;
  localparam int LATB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0, we0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, ram_we_a;
  logic [DW-1:0] rdata0_a, rdata1_a, ram_wdata_a, ram_rdata_a;
  logic [AW-1:0] ram_addr_a;
  logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, ram_we_b;
  logic [DW-1:0] rdata0_b, rdata1_b, ram_wdata_b, ram_rdata_b;
  logic [AW-1:0] ram_addr_b;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LATA), .MAX_LOCK(MAXL)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_gnt0(gnt0_a), .o_rvalid0(rvalid0_a), .o_rdata0(rdata0_a),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .i_lock1(lock1),
    .o_gnt1(gnt1_a), .o_rvalid1(rvalid1_a), .o_rdata1(rdata1_a),
    .o_ram_addr(ram_addr_a), .o_ram_wdata(ram_wdata_a), .o_ram_we(ram_we_a),
    .i_ram_rdata(ram_rdata_a)
  );

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LATB), .MAX_LOCK(MAXL)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_gnt0(gnt0_b), .o_rvalid0(rvalid0_b), .o_rdata0(rdata0_b),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .i_lock1(lock1),
    .o_gnt1(gnt1_b), .o_rvalid1(rvalid1_b), .o_rdata1(rdata1_b),
    .o_ram_addr(ram_addr_b), .o_ram_wdata(ram_wdata_b), .o_ram_we(ram_we_b),
    .i_ram_rdata(ram_rdata_b)
  );

  // ---------------------------------------------------------------------------
  // RAMs behind each DUT: read of the registered address, RD_LAT cycles later
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem_a [logic [AW-1:0]];
  logic [DW-1:0] mem_b [logic [AW-1:0]];
  logic [DW-1:0] pipe_b [0:2];

  initial begin
    ram_rdata_a = '0;
    ram_rdata_b = '0;
    pipe_b[0] = '0; pipe_b[1] = '0; pipe_b[2] = '0;
    forever begin
      @(posedge clk);
      ram_rdata_a = mem_a.exists(ram_addr_a) ? mem_a[ram_addr_a] : '0;
      if (ram_we_a) mem_a[ram_addr_a] = ram_wdata_a;
      pipe_b[2] = pipe_b[1];
      pipe_b[1] = pipe_b[0];
      pipe_b[0] = mem_b.exists(ram_addr_b) ? mem_b[ram_addr_b] : '0;
      ram_rdata_b = pipe_b[2];
      if (ram_we_b) mem_b[ram_addr_b] = ram_wdata_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            issued;
  } exp_t;

  exp_t          sb[$];
  int            head_a = 0;
  int            head_b = 0;
  logic [DW-1:0] gold [logic [AW-1:0]];
  int            m_last = 1;
  int            m_locked = 0;
  int            m_streak = 0;
  int            wait0 = 0;
  int            cyc = 0;
  logic          acc0 = 1'b0;
  logic          acc1 = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Winner under the arbitration rules: -1 none, 0 or 1.
  function automatic int pick(input logic r0, input logic r1, input logic l1);
    if (!r0 && !r1) return -1;
    if (m_locked != 0 && r1 && l1) return (r0 && m_streak >= MAXL) ? 0 : 1;
    if (m_locked != 0) return r0 ? 0 : 1;
    if (r0 && r1) return (m_last == 1) ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  initial forever begin
    int w;
    @(posedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      m_last = 1; m_locked = 0; m_streak = 0; wait0 = 0;
      head_a = sb.size();
      head_b = sb.size();
    end else begin
      w = pick(req0, req1, lock1);
      if (req0 && w != 0) wait0++;
      if (w == 0) begin
        checks++;
        if (wait0 > MAXL) begin
          errors++;
          $display("FAIL p0_wait: port 0 request took %0d cycles, limit %0d", wait0 + 1, MAXL + 1);
        end
        wait0 = 0;
      end
      if (w == 0) begin
        if (we0) gold[addr0] = wdata0;
        else sb.push_back('{0, gold.exists(addr0) ? gold[addr0] : '0, cyc});
      end else if (w == 1) begin
        if (we1) gold[addr1] = wdata1;
        else sb.push_back('{1, gold.exists(addr1) ? gold[addr1] : '0, cyc});
      end
      if (m_locked != 0 && !(req1 && lock1)) begin
        m_locked = 0; m_streak = 0;
      end else if (m_locked != 0) begin
        if (w == 0) m_streak = 0;
        else m_streak = (m_streak < MAXL) ? m_streak + 1 : MAXL;
      end else if (w == 1 && lock1) begin
        m_locked = 1; m_streak = 1;
      end
      if (w >= 0) m_last = w;
      acc0 = (w == 0);
      acc1 = (w == 1);
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Monitor: grants every cycle, read returns against the queue
  // ---------------------------------------------------------------------------
  task automatic mon(input string nm, input int lat, input logic rv0, input logic rv1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1, inout int head);
    exp_t e;
    if (head < sb.size() && sb[head].issued + 1 + lat < cyc) begin
      checks++; errors++;
      $display("FAIL %s_missing: no rvalid for read issued in cycle %0d, now cycle %0d",
               nm, sb[head].issued, cyc);
      head++;
    end
    if (rv0 && rv1) begin
      checks++; errors++;
      $display("FAIL %s_both_rvalid: rvalid0 and rvalid1 both 1 in cycle %0d", nm, cyc);
    end else if (rv0 || rv1) begin
      if (head >= sb.size()) begin
        checks++; errors++;
        $display("FAIL %s_unexpected: rvalid%0d with no outstanding read, cycle %0d",
                 nm, rv1 ? 1 : 0, cyc);
      end else begin
        e = sb[head];
        head++;
        chk({nm, "_owner"}, 64'(rv1), 64'(e.owner));
        chk({nm, "_data"}, 64'(rv1 ? d1 : d0), 64'(e.data));
        chk({nm, "_cycle"}, 64'(cyc), 64'(e.issued + 1 + lat));
      end
    end
  endtask

  initial forever begin
    int w;
    logic [1:0] eg;
    @(negedge clk);
    w  = rst ? -1 : pick(req0, req1, lock1);
    eg = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    chk("gnt_lat1", 64'({gnt1_a, gnt0_a}), 64'(eg));
    chk("gnt_lat3", 64'({gnt1_b, gnt0_b}), 64'(eg));
    mon("rd_lat1", LATA, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a, head_a);
    mon("rd_lat3", LATB, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b, head_b);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_acc(input int port);
    int k;
    for (k = 0; k < 30; k++) begin
      step();
      if (port == 0 ? acc0 : acc1) break;
    end
    if (k == 30) begin
      checks++; errors++;
      $display("FAIL accept_timeout: port %0d not accepted within 30 cycles", port);
    end
  endtask

  // lockmode: 0 never lock, 1 lock whenever port 1 requests, 2 random bursts
  task automatic run(input int n, input int p0, input int p1, input int lockmode, input int wepct);
    int burst;
    burst = 0;
    for (int i = 0; i < n; i++) begin
      if (!req0 || acc0) begin
        req0   = ($urandom_range(0, 99) < p0);
        we0    = ($urandom_range(0, 99) < wepct);
        addr0  = AW'($urandom_range(0, 15));
        wdata0 = $urandom();
      end
      if (!req1 || acc1) begin
        req1   = ($urandom_range(0, 99) < p1);
        we1    = ($urandom_range(0, 99) < wepct);
        addr1  = AW'($urandom_range(0, 15));
        wdata1 = $urandom();
        if (lockmode == 0) begin
          lock1 = 1'b0;
        end else if (lockmode == 1) begin
          lock1 = req1;
        end else if (burst > 0) begin
          lock1 = req1;
          burst--;
        end else begin
          lock1 = req1 && ($urandom_range(0, 9) == 0);
          if (lock1) burst = $urandom_range(4, 24);
        end
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ram_we",    64'({ram_we_b, ram_we_a}), 64'(0));
    chk("rst_ram_addr",  64'(ram_addr_a | ram_addr_b), 64'(0));
    chk("rst_ram_wdata", 64'(ram_wdata_a | ram_wdata_b), 64'(0));
    chk("rst_rvalid",    64'({rvalid1_b, rvalid0_b, rvalid1_a, rvalid0_a}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Port 0 write then read of the same word.
    req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00010; wdata0 = 32'hDEADBEEF;
    step();
    we0 = 1'b0;
    step();
    idle(6);

    // Continuous contended reads, no lock.
    run(16, 100, 100, 0, 0);
    idle(6);

    // Locked port-1 burst against a permanently requesting port 0.
    run(30, 100, 100, 1, 30);
    idle(6);

    // Reset one cycle after a read is accepted.
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00010;
    wait_acc(0);
    req0 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(6);
    run(6, 100, 100, 0, 0);
    idle(6);

    // Port 1 writes, port 0 reads the same word the following cycle.
    req1 = 1'b1; we1 = 1'b1; addr1 = 20'h00020; wdata1 = 32'h12345678; lock1 = 1'b0;
    wait_acc(1);
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00020;
    wait_acc(0);
    idle(6);

    // Mixed random traffic with random lock bursts.
    run(1500, 70, 70, 2, 40);
    idle(12);

    chk("drain_lat1", 64'(head_a), 64'(sb.size()));
    chk("drain_lat3", 64'(head_b), 64'(sb.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
